// File: rtl/bram_mem_responder.sv
// Block-RAM target for the CPU native memory port.
// Word reads, byte-strobed writes, fixed wait states, out-of-range error.
module bram_mem_responder #(
    parameter int unsigned DEPTH_WORDS = 1024,
    parameter logic [31:0] BASE_ADDR   = 32'h0000_0000,
    parameter int unsigned WAIT_STATES = 1,
    parameter string       INIT_FILE   = ""
) (
    input  logic        clk,
    input  logic        resetn,
    input  logic        mem_valid,
    input  logic [31:0] mem_addr,
    input  logic [31:0] mem_wdata,
    input  logic [3:0]  mem_wstrb,
    output logic        mem_ready,
    output logic [31:0] mem_rdata,
    output logic        mem_err
);

    localparam int unsigned AW = $clog2(DEPTH_WORDS);
    localparam logic [3:0]  WS = 4'(WAIT_STATES);
    localparam logic [32:0] LO = {1'b0, BASE_ADDR};
    localparam logic [32:0] HI = LO + 33'(DEPTH_WORDS) * 33'd4;

    typedef enum logic [1:0] {
        S_IDLE,
        S_WAIT,
        S_ACCESS,
        S_RESP
    } state_e;

    state_e      state_q, state_d;
    logic [3:0]  ctr_q, ctr_d;
    logic [AW-1:0] idx_q, idx_d;
    logic [31:0] wdata_q, wdata_d;
    logic [3:0]  wstrb_q, wstrb_d;
    logic        in_range_q, in_range_d;
    logic        ready_q, ready_d;
    logic        err_q, err_d;
    logic [31:0] rdata_q, rdata_d;
    logic [31:0] rd_word_q;

    logic [31:0] mem [DEPTH_WORDS];

    logic        req_in_range;
    logic [31:0] req_off;

    // 33-bit compare so the upper bound cannot wrap at the top of memory
    assign req_in_range = ({1'b0, mem_addr} >= LO) &&
                          ({1'b0, mem_addr} <  HI);
    assign req_off      = mem_addr - BASE_ADDR;

    always_comb begin
        state_d    = state_q;
        ctr_d      = ctr_q;
        idx_d      = idx_q;
        wdata_d    = wdata_q;
        wstrb_d    = wstrb_q;
        in_range_d = in_range_q;
        ready_d    = 1'b0;
        err_d      = 1'b0;
        rdata_d    = rdata_q;
        unique case (state_q)
            S_IDLE: begin
                if (mem_valid) begin
                    idx_d      = AW'(req_off >> 2);
                    wdata_d    = mem_wdata;
                    wstrb_d    = mem_wstrb;
                    in_range_d = req_in_range;
                    ctr_d      = WS;
                    state_d    = (WS == 4'd0) ? S_ACCESS : S_WAIT;
                end
            end
            S_WAIT: begin
                ctr_d = ctr_q - 4'd1;
                if (ctr_q == 4'd1) begin
                    state_d = S_ACCESS;
                end
            end
            S_ACCESS: begin
                state_d = S_RESP;
            end
            S_RESP: begin
                ready_d = 1'b1;
                err_d   = !in_range_q;
                if (!in_range_q) begin
                    rdata_d = 32'h0;
                end else if (wstrb_q == 4'h0) begin
                    rdata_d = rd_word_q;
                end
                state_d = S_IDLE;
            end
            default: begin
                state_d = S_IDLE;
            end
        endcase
    end

    always_ff @(posedge clk or negedge resetn) begin
        if (!resetn) begin
            state_q    <= S_IDLE;
            ctr_q      <= 4'd0;
            idx_q      <= '0;
            wdata_q    <= 32'h0;
            wstrb_q    <= 4'h0;
            in_range_q <= 1'b0;
            ready_q    <= 1'b0;
            err_q      <= 1'b0;
            rdata_q    <= 32'h0;
        end else begin
            state_q    <= state_d;
            ctr_q      <= ctr_d;
            idx_q      <= idx_d;
            wdata_q    <= wdata_d;
            wstrb_q    <= wstrb_d;
            in_range_q <= in_range_d;
            ready_q    <= ready_d;
            err_q      <= err_d;
            rdata_q    <= rdata_d;
        end
    end

    // Array has no reset so it maps onto block RAM
    always @(posedge clk) begin
        if (state_q == S_ACCESS && in_range_q) begin
            if (wstrb_q != 4'h0) begin
                for (int i = 0; i < 4; i++) begin
                    if (wstrb_q[i]) begin
                        mem[idx_q][8*i +: 8] <= wdata_q[8*i +: 8];
                    end
                end
            end else begin
                rd_word_q <= mem[idx_q];
            end
        end
    end

    initial begin
        for (int i = 0; i < int'(DEPTH_WORDS); i++) begin
            mem[i] = 32'h0;
        end
    end

    assign mem_ready = ready_q;
    assign mem_err   = err_q;
    assign mem_rdata = rdata_q;

endmodule

// File: tb/tb_bram_mem_responder.sv
// Scoreboard bench for bram_mem_responder.
// Three instances cover wait states 1, 0 and 7.
module tb_bram_mem_responder;

    typedef struct {
        logic [31:0] rd;
        logic        err;
        int          lat;
    } exp_t;

    logic        clk = 1'b0;
    logic        resetn;
    logic        valid [3];
    logic [31:0] addr  [3];
    logic [31:0] wdata [3];
    logic [3:0]  wstrb [3];
    logic        rdy   [3];
    logic [31:0] rdata [3];
    logic        err   [3];

    int          vec  = 0;
    int          miss = 0;
    exp_t        exp_q [$];

    logic [31:0] mdl [3][32];
    logic [31:0] last_rd [3];
    int          depth [3] = '{32, 16, 16};
    logic [31:0] base  [3] = '{32'h0, 32'h0, 32'h1000};
    int          ws    [3] = '{1, 0, 7};

    always #5 clk = ~clk;

    bram_mem_responder #(
        .DEPTH_WORDS(32), .BASE_ADDR(32'h0),
        .WAIT_STATES(1), .INIT_FILE("")
    ) u0 (
        .clk(clk), .resetn(resetn),
        .mem_valid(valid[0]), .mem_addr(addr[0]),
        .mem_wdata(wdata[0]), .mem_wstrb(wstrb[0]),
        .mem_ready(rdy[0]), .mem_rdata(rdata[0]),
        .mem_err(err[0])
    );

    bram_mem_responder #(
        .DEPTH_WORDS(16), .BASE_ADDR(32'h0),
        .WAIT_STATES(0), .INIT_FILE("")
    ) u1 (
        .clk(clk), .resetn(resetn),
        .mem_valid(valid[1]), .mem_addr(addr[1]),
        .mem_wdata(wdata[1]), .mem_wstrb(wstrb[1]),
        .mem_ready(rdy[1]), .mem_rdata(rdata[1]),
        .mem_err(err[1])
    );

    bram_mem_responder #(
        .DEPTH_WORDS(16), .BASE_ADDR(32'h1000),
        .WAIT_STATES(7), .INIT_FILE("")
    ) u2 (
        .clk(clk), .resetn(resetn),
        .mem_valid(valid[2]), .mem_addr(addr[2]),
        .mem_wdata(wdata[2]), .mem_wstrb(wstrb[2]),
        .mem_ready(rdy[2]), .mem_rdata(rdata[2]),
        .mem_err(err[2])
    );

    // Starts mid-cycle, returns inside the mem_ready cycle.
    task automatic xact(input int k, input logic [31:0] a,
                        input logic [31:0] d, input logic [3:0] s,
                        input string nm);
        exp_t        e;
        exp_t        got;
        bit          inr;
        int          idx;
        int          lat;
        logic [31:0] off;
        inr = ({1'b0, a} >= {1'b0, base[k]}) &&
              ({1'b0, a} < ({1'b0, base[k]} + 33'(4 * depth[k])));
        off = a - base[k];
        idx = int'(off >> 2);
        e.err = !inr;
        e.lat = ws[k] + 2;
        if (!inr) begin
            e.rd = 32'h0;
            last_rd[k] = 32'h0;
        end else if (s == 4'h0) begin
            e.rd = mdl[k][idx];
            last_rd[k] = e.rd;
        end else begin
            for (int i = 0; i < 4; i++)
                if (s[i]) mdl[k][idx][8*i +: 8] = d[8*i +: 8];
            e.rd = last_rd[k];
        end
        exp_q.push_back(e);
        valid[k] = 1'b1;
        addr[k]  = a;
        wdata[k] = d;
        wstrb[k] = s;
        @(posedge clk);
        #1;
        vec++;
        if (rdy[k] !== 1'b0) begin
            miss++;
            $display("FAIL %s ready_after_accept got %b want 0", nm, rdy[k]);
        end
        addr[k]  = $urandom;
        wdata[k] = $urandom;
        wstrb[k] = 4'($urandom);
        lat = 0;
        do begin
            @(posedge clk);
            #1;
            lat++;
        end while (rdy[k] !== 1'b1 && lat < 40);
        valid[k] = 1'b0;
        got = exp_q.pop_front();
        vec++;
        if (lat !== got.lat) begin
            miss++;
            $display("FAIL %s latency got %0d want %0d", nm, lat, got.lat);
        end
        vec++;
        if (rdata[k] !== got.rd) begin
            miss++;
            $display("FAIL %s rdata got %h want %h", nm, rdata[k], got.rd);
        end
        vec++;
        if (err[k] !== got.err) begin
            miss++;
            $display("FAIL %s err got %b want %b", nm, err[k], got.err);
        end
    endtask

    task automatic check_idle(input string nm);
        for (int k = 0; k < 3; k++) begin
            vec++;
            if (rdy[k] !== 1'b0 || err[k] !== 1'b0 || rdata[k] !== 32'h0) begin
                miss++;
                $display("FAIL %s dut%0d got rdy=%b err=%b rdata=%h want 0/0/0",
                         nm, k, rdy[k], err[k], rdata[k]);
            end
        end
    endtask

    task automatic test_reset;
        for (int k = 0; k < 3; k++) begin
            valid[k] = 1'b0;
            addr[k]  = 32'h0;
            wdata[k] = 32'h0;
            wstrb[k] = 4'h0;
            last_rd[k] = 32'h0;
        end
        resetn = 1'b1;
        #1;
        resetn = 1'b0;
        #1;
        check_idle("reset_async");
        repeat (2) @(posedge clk);
        #1;
        check_idle("reset_hold");
        @(negedge clk);
        resetn = 1'b1;
        @(negedge clk);
    endtask

    task automatic test_basic;
        xact(0, 32'h10, 32'hDEAD_BEEF, 4'hF, "t1_wr");
        xact(0, 32'h10, 32'h0, 4'h0, "t1_rd");
    endtask

    task automatic test_strobe;
        xact(0, 32'h20, 32'h1122_3344, 4'hF, "t2_init");
        xact(0, 32'h20, 32'hAABB_CCDD, 4'b0101, "t2_wr");
        xact(0, 32'h20, 32'h0, 4'h0, "t2_rd");
        vec++;
        if (rdata[0] !== 32'h11BB_33DD) begin
            miss++;
            $display("FAIL t2_merge got %h want 11bb33dd", rdata[0]);
        end
    endtask

    task automatic test_latency;
        xact(1, 32'h08, 32'hCAFE_F00D, 4'hF, "t3_ws0_wr");
        xact(1, 32'h08, 32'h0, 4'h0, "t3_ws0_rd");
        xact(2, 32'h103C, 32'h1357_9BDF, 4'hF, "t3_ws7_wr");
        xact(2, 32'h103C, 32'h0, 4'h0, "t3_ws7_rd");
    endtask

    task automatic test_out_of_range;
        xact(0, 32'h00, 32'hA5A5_0000, 4'hF, "t4_w0");
        xact(0, 32'h7C, 32'h5A5A_FFFF, 4'hF, "t4_wlast");
        xact(0, 32'h80, 32'h0, 4'h0, "t4_rd_hi");
        xact(0, 32'hFFFF_FFFC, 32'hFFFF_FFFF, 4'hF, "t4_wr_lo");
        xact(0, 32'h00, 32'h0, 4'h0, "t4_rb0");
        xact(0, 32'h7C, 32'h0, 4'h0, "t4_rblast");
        xact(2, 32'h0FFC, 32'h0, 4'h0, "t4_ws7_lo");
        xact(2, 32'h1040, 32'h0, 4'h0, "t4_ws7_hi");
    endtask

    task automatic test_reset_abort;
        xact(0, 32'h40, 32'h0102_0304, 4'hF, "t5_init");
        @(negedge clk);
        valid[0] = 1'b1;
        addr[0]  = 32'h40;
        wdata[0] = 32'hFFFF_FFFF;
        wstrb[0] = 4'hF;
        @(posedge clk);
        #2;
        resetn = 1'b0;
        #1;
        vec++;
        if (rdy[0] !== 1'b0) begin
            miss++;
            $display("FAIL t5_abort_ready got %b want 0", rdy[0]);
        end
        valid[0] = 1'b0;
        repeat (2) @(posedge clk);
        #1;
        check_idle("t5_in_reset");
        @(negedge clk);
        resetn = 1'b1;
        for (int k = 0; k < 3; k++) last_rd[k] = 32'h0;
        @(negedge clk);
        xact(0, 32'h40, 32'h0, 4'h0, "t5_after");
    endtask

    task automatic test_back_to_back;
        @(negedge clk);
        xact(0, 32'h13, 32'h0, 4'h0, "t6_rd11");
        xact(0, 32'h10, 32'h0, 4'h0, "t6_rd00");
        xact(0, 32'h24, 32'h7788_99AA, 4'b1100, "t6_wr");
        xact(0, 32'h27, 32'h0, 4'h0, "t6_rd27");
        xact(1, 32'h0B, 32'h0, 4'h0, "t6_ws0_rd");
        xact(1, 32'h3C, 32'h0BAD_F00D, 4'hF, "t6_ws0_wr");
        xact(1, 32'h3F, 32'h0, 4'h0, "t6_ws0_rb");
    endtask

    initial begin
        for (int k = 0; k < 3; k++)
            for (int i = 0; i < 32; i++)
                mdl[k][i] = 32'h0;
        test_reset();
        test_basic();
        test_strobe();
        test_latency();
        test_out_of_range();
        test_reset_abort();
        test_back_to_back();
        vec++;
        if (exp_q.size() !== 0) begin
            miss++;
            $display("FAIL scoreboard_drain got %0d want 0", exp_q.size());
        end
        $display("== %0d vectors applied, %0d miscompares ==", vec, miss);
        $finish;
    end

endmodule
